// File: rtl/wbr_chain_ctrl.sv
// wbr_chain_ctrl: serial load/apply/capture/unload controller for a WBR chain.
// Ports: clk/rst, start + pattern_in request, busy/done/response status, SE/HE/WSI/WSO chain side.
module wbr_chain_ctrl #(
  parameter int CHAIN_LEN    = 20,
  parameter int APPLY_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 SE,
  output logic                 HE,
  output logic                 WSI,
  input  logic                 WSO
);

  localparam int MAX_CNT = (CHAIN_LEN > APPLY_CYCLES) ? CHAIN_LEN : APPLY_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] APPLY_LAST = CW'(APPLY_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SHIFT_IN  = 3'd1;
  localparam logic [2:0] S_APPLY     = 3'd2;
  localparam logic [2:0] S_CAPTURE   = 3'd3;
  localparam logic [2:0] S_SHIFT_OUT = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sreg_q, sreg_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sreg_d  = pattern_in;
          cnt_d   = '0;
          state_d = S_SHIFT_IN;
        end
      end
      S_SHIFT_IN: begin
        // MSB goes out first so it travels to the far end of the chain
        sreg_d = {sreg_q[CHAIN_LEN-2:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = S_APPLY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_APPLY: begin
        if (cnt_q == APPLY_LAST) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        cnt_d   = '0;
        state_d = S_SHIFT_OUT;
      end
      S_SHIFT_OUT: begin
        // far cell emerges first and ends up in the MSB
        resp_d = {resp_q[CHAIN_LEN-2:0], WSO};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      resp_q  <= resp_d;
    end
  end

  // all outputs are pure decodes of registered state
  assign SE       = (state_q == S_SHIFT_IN) || (state_q == S_SHIFT_OUT);
  assign HE       = (state_q == S_SHIFT_IN) || (state_q == S_APPLY)
                 || (state_q == S_SHIFT_OUT);
  assign WSI      = (state_q == S_SHIFT_IN) && sreg_q[CHAIN_LEN-1];
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign response = resp_q;

endmodule

// File: tb/tb_wbr_chain_ctrl.sv
// tb_wbr_chain_ctrl: table, directed and random checks of wbr_chain_ctrl
// against behavioural WBR cell chains (20-cell default and 2-cell/3-apply).
module tb_wbr_chain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        start_a = 1'b0;
  logic [19:0] pat_a = '0;
  logic        busy_a, done_a, se_a, he_a, wsi_a, wso_a;
  logic [19:0] resp_a;
  logic [19:0] ch_a = '0;
  logic [19:0] cfi_a = '0;
  logic [19:0] cfo_a;

  logic        start_b = 1'b0;
  logic [1:0]  pat_b = '0;
  logic        busy_b, done_b, se_b, he_b, wsi_b, wso_b;
  logic [1:0]  resp_b;
  logic [1:0]  ch_b = '0;
  logic [1:0]  cfi_b = '0;
  logic [1:0]  cfo_b;

  int n_tests = 0;
  int n_fail  = 0;

  wbr_chain_ctrl #(.CHAIN_LEN(20), .APPLY_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pattern_in(pat_a),
    .busy(busy_a), .done(done_a), .response(resp_a),
    .SE(se_a), .HE(he_a), .WSI(wsi_a), .WSO(wso_a)
  );

  wbr_chain_ctrl #(.CHAIN_LEN(2), .APPLY_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pattern_in(pat_b),
    .busy(busy_b), .done(done_b), .response(resp_b),
    .SE(se_b), .HE(he_b), .WSI(wsi_b), .WSO(wso_b)
  );

  // WBR cell models: flop takes CTI when SE, else CFO; CFO = HE ? CTO : CFI
  assign cfo_a = he_a ? ch_a : cfi_a;
  assign wso_a = ch_a[19];
  assign cfo_b = he_b ? ch_b : cfi_b;
  assign wso_b = ch_b[1];

  always @(posedge clk) begin
    if (se_a) ch_a <= {ch_a[18:0], wsi_a};
    else      ch_a <= cfo_a;
    if (se_b) ch_b <= {ch_b[0], wsi_b};
    else      ch_b <= cfo_b;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One operation on the 20-cell chain; called on a negedge.
  // Offset k counts edges after the edge that samples start.
  task automatic op_a(input logic [19:0] p, input logic [19:0] c,
                      input int abort_at, input int disturb_at,
                      input string tag);
    int lat = -1;
    int dones = 0;
    int wsi_bad = 0;
    int cfo_bad = 0;
    int busy_bad = 0;
    logic busy_after = 1'b1;
    logic [19:0] r = '0;
    pat_a   = p;
    cfi_a   = c;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k < 20) begin
        if (wsi_a !== p[19-k] || se_a !== 1'b1 || he_a !== 1'b1)
          wsi_bad++;
      end else if (k == 20) begin
        if (cfo_a !== p || se_a !== 1'b0 || he_a !== 1'b1) cfo_bad++;
      end
      if (k <= 42 && abort_at < 0 && busy_a !== 1'b1) busy_bad++;
      if (done_a === 1'b1) begin
        dones++;
        if (lat < 0) begin
          lat = k;
          r = resp_a;
        end
      end
      if (k == 43) busy_after = busy_a;
      if (k == disturb_at) begin
        start_a = 1'b1;
        pat_a   = 20'hFFFFF;
      end
      if (k == disturb_at + 1) start_a = 1'b0;
      if (abort_at >= 0 && k == abort_at + 1) begin
        chk({tag, " abort busy"}, 32'(busy_a), 32'd0);
        chk({tag, " abort resp"}, 32'(resp_a), 32'd0);
        chk({tag, " abort ctl"}, {29'd0, se_a, he_a, wsi_a}, 32'd0);
        rst = 1'b0;
      end
      if (k == abort_at) rst = 1'b1;
      @(negedge clk);
    end
    chk({tag, " wsi/shift"}, 32'(wsi_bad), 32'd0);
    chk({tag, " apply cfo"}, 32'(cfo_bad), 32'd0);
    if (abort_at >= 0) begin
      chk({tag, " no done"}, 32'(dones), 32'd0);
    end else begin
      chk({tag, " latency"}, 32'(lat), 32'd42);
      chk({tag, " response"}, 32'(r), 32'(c));
      chk({tag, " done count"}, 32'(dones), 32'd1);
      chk({tag, " busy span"}, 32'(busy_bad), 32'd0);
      chk({tag, " busy fall"}, 32'(busy_after), 32'd0);
      chk({tag, " resp hold"}, 32'(resp_a), 32'(c));
    end
  endtask

  typedef struct {
    logic [19:0] pat;
    logic [19:0] cfi;
    logic [19:0] exp_resp;
    string       name;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{20'hA5A5C, 20'h0F0F3, 20'h0F0F3, "basic"};
    tbl[1] = '{20'h00001, 20'h80000, 20'h80000, "walk1"};
    tbl[2] = '{20'hFFFFF, 20'h00000, 20'h00000, "ones_in"};
    tbl[3] = '{20'h00000, 20'hFFFFF, 20'hFFFFF, "ones_cap"};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset done", 32'(done_a), 32'd0);
    chk("reset ctl", {29'd0, se_a, he_a, wsi_a}, 32'd0);
    chk("reset resp", 32'(resp_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      op_a(tbl[i].pat, tbl[i].cfi, -1, -1, tbl[i].name);
      chk({tbl[i].name, " tbl resp"}, 32'(resp_a), 32'(tbl[i].exp_resp));
    end

    // mid-IDLE reset clears a non-zero response
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle rst resp", 32'(resp_a), 32'd0);
    chk("idle rst ctl", {28'd0, se_a, he_a, wsi_a, busy_a}, 32'd0);
    chk("idle rst done", 32'(done_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // abort in SHIFT_OUT cycle 5, then a clean operation
    op_a(20'h3C3C3, 20'h5A5A5, 27, -1, "abort");
    op_a(20'h12345, 20'hABCDE, -1, -1, "post_abort");

    // start and pattern disturbance during SHIFT_IN
    op_a(20'h6B2D1, 20'h1E1E1, -1, 5, "ignore");

    for (int i = 0; i < 6; i++) begin
      logic [19:0] rp, rc;
      rp = 20'($urandom);
      rc = 20'($urandom);
      op_a(rp, rc, -1, -1, $sformatf("rand%0d", i));
    end

    // 2-cell chain, 3 apply cycles, start held high
    begin
      int nd = 0;
      int d1 = -1;
      int d2 = -1;
      int bad = 0;
      logic idle_busy = 1'b1;
      logic [1:0] rb = '0;
      pat_b   = 2'b10;
      cfi_b   = 2'b01;
      start_b = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 40; k++) begin
        if (k == 0 && wsi_b !== 1'b1) bad++;
        if (k == 1 && wsi_b !== 1'b0) bad++;
        if (k >= 2 && k <= 4 && cfo_b !== 2'b10) bad++;
        if (done_b === 1'b1) begin
          nd++;
          if (nd == 1) begin
            d1 = k;
            rb = resp_b;
          end else if (nd == 2) begin
            d2 = k;
          end
        end
        if (k == 9) idle_busy = busy_b;
        if (k == 19) start_b = 1'b0;
        @(negedge clk);
      end
      chk("p2 first done", 32'(d1), 32'd8);
      chk("p2 second done", 32'(d2), 32'd18);
      chk("p2 done count", 32'(nd), 32'd2);
      chk("p2 response", 32'(rb), 32'd1);
      chk("p2 shift/apply", 32'(bad), 32'd0);
      chk("p2 idle gap", 32'(idle_busy), 32'd0);
      chk("p2 final busy", 32'(busy_b), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
